axis_hex_encoder: RTL
=====================

# axis_hex_encoder

- Converts an AXI-Stream byte stream into printable ASCII hex characters: two characters per input byte, most-significant nibble first.
- Optionally appends CR/LF at each input packet boundary.
- Sits directly downstream of the byte-processing ALU stage and upstream of the UART transmit path, so processed bytes can be viewed on a terminal.
- Single clock domain; fully registered state, with AXI-Stream handshakes on both sides.

## Interface
Parameters:
- `INCLUDE_CRLF`, 1: when 1, emit 0x0D, 0x0A after the last byte of each input packet.
- `UPPERCASE`, 1: hex letters use 0x41–0x46 ("A"–"F") when 1, 0x61–0x66 ("a"–"f") when 0.

Ports:
- Clock and reset (one clock; reset is synchronous and active-high):
  - `aclk_i`  in  1  clock.
  - `rst_i`  in  1  synchronous active-high reset.
- Slave side, byte input:
  - `s_axis_tvalid_i`  in  1  input byte valid.
  - `s_axis_tready_o`  out  1  encoder can accept a byte.
  - `s_axis_tdata_i`  in  8  input byte.
  - `s_axis_tlast_i`  in  1  byte is last of packet.
- Master side, ASCII output:
  - `m_axis_tvalid_o`  out  1  output character valid.
  - `m_axis_tready_i`  in  1  downstream accepts character.
  - `m_axis_tdata_o`  out  8  ASCII character.
  - `m_axis_tlast_o`  out  1  final character of the packet.

## Operation
- State machine states: IDLE, HI, LO, CR, LF. Holding registers: `byte_q[7:0]`, `last_q`.
- IDLE:
  - `s_axis_tready_o`=1, `m_axis_tvalid_o`=0.
  - On s-handshake: capture data into `byte_q` and tlast into `last_q`, then go to HI.
- HI:
  - `m_axis_tvalid_o`=1, tdata = ascii(`byte_q[7:4]`), tlast=0.
  - On m-handshake go to LO.
- LO:
  - `m_axis_tvalid_o`=1, tdata = ascii(`byte_q[3:0]`).
  - tlast = `last_q` && !INCLUDE_CRLF.
  - On m-handshake:
    - if `last_q` && INCLUDE_CRLF, go to CR;
    - else if an s-handshake occurs in the same cycle, capture the new byte and go to HI;
    - else go to IDLE.
- CR: tdata=0x0D, tlast=0. On m-handshake go to LF.
- LF: tdata=0x0A, tlast=1. On m-handshake go to IDLE.
- Tready rule: `s_axis_tready_o` = (state==IDLE) || (state==LO && `m_axis_tready_i` && !(`last_q` && INCLUDE_CRLF)).
  - This is a combinational path from `m_axis_tready_i`; that path is permitted.
- Nibble encoding: 0–9 map to 0x30–0x39; 10–15 map to 0x41–0x46 or 0x61–0x66 according to UPPERCASE.
- Input `tlast`=0 for all bytes: no CR/LF is emitted and `m_axis_tlast_o` is never asserted.
- Upstream `tuser` is not consumed.

## Timing
- Reset (`rst_i` high at a clock edge):
  - next state is IDLE; `byte_q`=0, `last_q`=0;
  - `m_axis_tvalid_o`=0, `m_axis_tdata_o`=0x00, `m_axis_tlast_o`=0;
  - `s_axis_tready_o`=0 while `rst_i` is high and 1 in the first cycle after release.
- Reset mid-packet (any state): the in-flight byte and any pending CR/LF are discarded, with no partial output after reset.
- Latency: byte accepted at edge N; its HI character is valid in the cycle after edge N.
- Throughput with `m_axis_tready_i`=1:
  - sustained 2 output characters/cycle-pair per byte (one input byte every 2 cycles);
  - packet ends add 2 cycles for CR/LF when enabled;
  - the first byte after IDLE costs one extra cycle.
- Backpressure: while `m_axis_tvalid_o`=1 and `m_axis_tready_i`=0, tdata and tlast hold stable and the state does not advance.
- Outputs are driven from state and holding registers only; `m_axis_tvalid_o` never depends combinationally on slave inputs.

## Structure
- Package `hex_pkg`:
  - state enum `hex_state_e` (IDLE, HI, LO, CR, LF);
  - constants `ASCII_CR`=8'h0D and `ASCII_LF`=8'h0A;
  - function `nibble_to_ascii(nibble, uppercase)`.
- Single module, no sub-module; encoding uses the package function.

## Test plan
- Byte 0x3C with tlast=1, INCLUDE_CRLF=1, ready held high -> 0x33, 0x43, 0x0D, 0x0A on consecutive cycles, tlast only on 0x0A.
- Bytes 0xA5 then 0x0F (tlast on 0x0F), ready high -> 0x41, 0x35, 0x30, 0x46, 0x0D, 0x0A with no gap between bytes; `s_axis_tready_o` low during HI, CR and LF.
- Backpressure: same stream with `m_axis_tready_i` toggling 1,0,1,0 -> identical character sequence, and tdata/tlast stable across every stalled cycle, with no drops or duplicates.
- UPPERCASE=0, INCLUDE_CRLF=0, byte 0xBE tlast=1 -> 0x62, 0x65, with tlast on 0x65.
- Assert `rst_i` for one cycle while in LO holding 0xA5 -> `m_axis_tvalid_o`=0 the next cycle; then byte 0x12 -> 0x31, 0x32 only, with no stale 0x35.
- Bytes 0x00 and 0xFF with tlast=0, INCLUDE_CRLF=1 -> 0x30, 0x30, 0x46, 0x46, with no CR/LF and tlast never asserted.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared types and helpers for the AXI-Stream byte-to-ASCII-hex encoder.
// Holds the FSM state encoding, the line-ending characters and the nibble
// encoder used to build printable output characters.
package hex_pkg;

    // Encoder FSM states: waiting for a byte, high nibble, low nibble, CR, LF
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        CR   = 3'd3,
        LF   = 3'd4
    } hex_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Map a 4-bit value to its printable hex digit ('0'-'9', then 'A'-'F' or 'a'-'f')
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble,
                                                   input logic       uppercase);
        logic [7:0] w_base;
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        w_base = uppercase ? 8'h41 : 8'h61;
        return w_base + {4'h0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/axis_hex_encoder.sv
// AXI-Stream byte to ASCII hex encoder.
// Each input byte becomes two printable characters, high nibble first; when
// INCLUDE_CRLF is set a CR/LF pair closes every input packet. Output beats are
// fully registered so the master side never depends on slave inputs.
module axis_hex_encoder
    import hex_pkg::*;
#(
    parameter bit INCLUDE_CRLF = 1'b1,
    parameter bit UPPERCASE    = 1'b1
) (
    input  logic       aclk_i,
    input  logic       rst_i,

    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    input  logic [7:0] s_axis_tdata_i,
    input  logic       s_axis_tlast_i,

    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic [7:0] m_axis_tdata_o,
    output logic       m_axis_tlast_o
);

    hex_state_e r_state;
    logic [7:0] r_byte;
    logic       r_last;
    logic       r_tvalid;
    logic [7:0] r_tdata;
    logic       r_tlast;

    logic       w_crlf_pending;
    logic       w_s_ready;
    logic       w_s_hs;
    logic       w_m_hs;

    // A CR/LF pair follows the current byte only if it closed a packet
    assign w_crlf_pending = r_last && INCLUDE_CRLF;

    // Accept a new byte when idle, or in LO while the low nibble is leaving
    // this cycle and no line ending has to be inserted first
    assign w_s_ready = !rst_i &&
                       ((r_state == IDLE) ||
                        ((r_state == LO) && m_axis_tready_i && !w_crlf_pending));

    assign w_s_hs = s_axis_tvalid_i && w_s_ready;
    assign w_m_hs = r_tvalid && m_axis_tready_i;

    assign s_axis_tready_o = w_s_ready;
    assign m_axis_tvalid_o = r_tvalid;
    assign m_axis_tdata_o  = r_tdata;
    assign m_axis_tlast_o  = r_tlast;

    // Encoder FSM: advances on handshakes and preloads the next output beat
    always_ff @(posedge aclk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_byte   <= 8'h00;
            r_last   <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= 8'h00;
            r_tlast  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_s_hs) begin
                        r_byte   <= s_axis_tdata_i;
                        r_last   <= s_axis_tlast_i;
                        r_state  <= HI;
                        r_tvalid <= 1'b1;
                        r_tdata  <= nibble_to_ascii(s_axis_tdata_i[7:4], UPPERCASE);
                        r_tlast  <= 1'b0;
                    end
                end

                HI: begin
                    if (w_m_hs) begin
                        r_state <= LO;
                        r_tdata <= nibble_to_ascii(r_byte[3:0], UPPERCASE);
                        r_tlast <= r_last && !INCLUDE_CRLF;
                    end
                end

                LO: begin
                    if (w_m_hs) begin
                        if (w_crlf_pending) begin
                            r_state <= CR;
                            r_tdata <= ASCII_CR;
                            r_tlast <= 1'b0;
                        end else if (w_s_hs) begin
                            // Back-to-back byte: skip IDLE to keep one byte per two cycles
                            r_byte  <= s_axis_tdata_i;
                            r_last  <= s_axis_tlast_i;
                            r_state <= HI;
                            r_tdata <= nibble_to_ascii(s_axis_tdata_i[7:4], UPPERCASE);
                            r_tlast <= 1'b0;
                        end else begin
                            r_state  <= IDLE;
                            r_tvalid <= 1'b0;
                            r_tdata  <= 8'h00;
                            r_tlast  <= 1'b0;
                        end
                    end
                end

                CR: begin
                    if (w_m_hs) begin
                        r_state <= LF;
                        r_tdata <= ASCII_LF;
                        r_tlast <= 1'b1;
                    end
                end

                LF: begin
                    if (w_m_hs) begin
                        r_state  <= IDLE;
                        r_tvalid <= 1'b0;
                        r_tdata  <= 8'h00;
                        r_tlast  <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_tvalid <= 1'b0;
                    r_tdata  <= 8'h00;
                    r_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule
